sgd_sequencer: RTL and testbench

- Control block ahead of the SGD gradient datapath.
- After reset it deserialises the LSB-first training stream on S into 16-bit words and issues write commands to the sample memory.
- It then schedules one gradient step per (epoch, data point) over a start/done handshake and raises SGD_DONE when all epochs finish.

---
 rtl/sgd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_sgd_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sgd_sequencer.sv
// Front-end sequencer for the SGD gradient datapath: deserialises the LSB-first
// training stream into sample memory, then schedules one step per (epoch, point).
module sgd_sequencer #(
  parameter int WORD_W = 16,
  parameter int FEAT_W = 4,
  parameter int PTS_W  = 12,
  parameter int EP_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              S,
  input  logic [FEAT_W-1:0] feat,
  input  logic [PTS_W-1:0]  data_points,
  input  logic [EP_W-1:0]   epoch,
  input  logic [3:0]        learn_rate,
  output logic              mem_we,
  output logic [PTS_W-1:0]  mem_point,
  output logic [FEAT_W-1:0] mem_word,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              step_start,
  output logic [PTS_W-1:0]  step_point,
  output logic [EP_W-1:0]   step_epoch,
  output logic [3:0]        lr_out,
  input  logic              step_done,
  output logic              busy,
  output logic              SGD_DONE
);

  localparam int BIT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {ST_LOAD, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [FEAT_W-1:0]   feat_q, feat_d;
  logic [PTS_W-1:0]    dp_q, dp_d;
  logic [EP_W-1:0]     ep_q, ep_d;
  logic [3:0]          lr_q, lr_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [PTS_W-1:0]    lp_q, lp_d;
  logic [FEAT_W-1:0]   lw_q, lw_d;
  logic                mem_we_q, mem_we_d;
  logic [PTS_W-1:0]    mem_point_q, mem_point_d;
  logic [FEAT_W-1:0]   mem_word_q, mem_word_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                step_start_q, step_start_d;
  logic [PTS_W-1:0]    sp_q, sp_d;
  logic [EP_W-1:0]     se_q, se_d;
  logic [3:0]          lr_out_q, lr_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d      = state_q;
    feat_d       = feat_q;
    dp_d         = dp_q;
    ep_d         = ep_q;
    lr_d         = lr_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    lp_d         = lp_q;
    lw_d         = lw_q;
    mem_we_d     = 1'b0;
    mem_point_d  = mem_point_q;
    mem_word_d   = mem_word_q;
    mem_wdata_d  = mem_wdata_q;
    step_start_d = 1'b0;
    sp_d         = sp_q;
    se_d         = se_q;
    lr_out_d     = lr_out_q;
    busy_d       = busy_q;
    done_d       = done_q;

    if (RST) begin
      feat_d      = feat;
      dp_d        = data_points;
      ep_d        = epoch;
      lr_d        = learn_rate;
      state_d     = (data_points == '0 || epoch == '0) ? ST_DONE : ST_LOAD;
      bit_d       = '0;
      shift_d     = '0;
      lp_d        = '0;
      lw_d        = '0;
      mem_point_d = '0;
      mem_word_d  = '0;
      mem_wdata_d = '0;
      sp_d        = '0;
      se_d        = '0;
      lr_out_d    = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          // lp_q reaching dp_q means every point is stored; this edge only hands over to ISSUE
          if (lp_q == dp_q) begin
            state_d = ST_ISSUE;
          end else begin
            shift_d = {S, shift_q[WORD_W-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(WORD_W - 1)) begin
              bit_d       = '0;
              mem_we_d    = 1'b1;
              mem_point_d = lp_q;
              mem_word_d  = feat_q - lw_q;
              mem_wdata_d = {S, shift_q[WORD_W-1:1]};
              if (lw_q == feat_q) begin
                lw_d = '0;
                lp_d = lp_q + PTS_W'(1);
              end else begin
                lw_d = lw_q + FEAT_W'(1);
              end
            end
          end
        end
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT: begin
          if (step_done) begin
            if (sp_q == dp_q - PTS_W'(1)) begin
              sp_d    = '0;
              se_d    = se_q + EP_W'(1);
              state_d = (se_q == ep_q - EP_W'(1)) ? ST_DONE : ST_ISSUE;
            end else begin
              sp_d    = sp_q + PTS_W'(1);
              state_d = ST_ISSUE;
            end
          end
        end
        default: ;
      endcase
      step_start_d = (state_d == ST_ISSUE);
      busy_d       = (state_d != ST_DONE);
      done_d       = (state_d == ST_DONE);
      lr_out_d     = lr_q;
    end
  end

  always_ff @(posedge CLK) begin
    state_q      <= state_d;
    feat_q       <= feat_d;
    dp_q         <= dp_d;
    ep_q         <= ep_d;
    lr_q         <= lr_d;
    bit_q        <= bit_d;
    shift_q      <= shift_d;
    lp_q         <= lp_d;
    lw_q         <= lw_d;
    mem_we_q     <= mem_we_d;
    mem_point_q  <= mem_point_d;
    mem_word_q   <= mem_word_d;
    mem_wdata_q  <= mem_wdata_d;
    step_start_q <= step_start_d;
    sp_q         <= sp_d;
    se_q         <= se_d;
    lr_out_q     <= lr_out_d;
    busy_q       <= busy_d;
    done_q       <= done_d;
  end

  assign mem_we     = mem_we_q;
  assign mem_point  = mem_point_q;
  assign mem_word   = mem_word_q;
  assign mem_wdata  = mem_wdata_q;
  assign step_start = step_start_q;
  assign step_point = sp_q;
  assign step_epoch = se_q;
  assign lr_out     = lr_out_q;
  assign busy       = busy_q;
  assign SGD_DONE   = done_q;

endmodule

// File: tb/tb_sgd_sequencer.sv
// Randomised bench for sgd_sequencer: an event-level model predicts write strobes,
// step requests and completion from the stream length and the done handshake.
module tb_sgd_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        S = 1'b0;
  logic [3:0]  feat = '0;
  logic [11:0] data_points = '0;
  logic [7:0]  epoch = '0;
  logic [3:0]  learn_rate = '0;
  logic        step_done = 1'b0;
  logic        mem_we, step_start, busy, SGD_DONE;
  logic [11:0] mem_point, step_point;
  logic [3:0]  mem_word, lr_out;
  logic [15:0] mem_wdata;
  logic [7:0]  step_epoch;

  int vec = 0;
  int mis = 0;
  logic [15:0] words[$];

  always #5 CLK = ~CLK;

  sgd_sequencer dut (
    .CLK(CLK), .RST(RST), .S(S), .feat(feat), .data_points(data_points),
    .epoch(epoch), .learn_rate(learn_rate), .mem_we(mem_we), .mem_point(mem_point),
    .mem_word(mem_word), .mem_wdata(mem_wdata), .step_start(step_start),
    .step_point(step_point), .step_epoch(step_epoch), .lr_out(lr_out),
    .step_done(step_done), .busy(busy), .SGD_DONE(SGD_DONE)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_we"},    32'(mem_we), 0);
    chk({nm, "_mpt"},   32'(mem_point), 0);
    chk({nm, "_mwd"},   32'(mem_word), 0);
    chk({nm, "_mdat"},  32'(mem_wdata), 0);
    chk({nm, "_start"}, 32'(step_start), 0);
    chk({nm, "_spt"},   32'(step_point), 0);
    chk({nm, "_sep"},   32'(step_epoch), 0);
    chk({nm, "_lr"},    32'(lr_out), 0);
    chk({nm, "_busy"},  32'(busy), 0);
    chk({nm, "_done"},  32'(SGD_DONE), 0);
  endtask

  // mode 0: done three cycles after each start plus spurious pulses; mode 1: random done
  task automatic run_test(input int tag, input int f, input int d, input int e,
                          input int l, input int mode, input bit abort, input int rc);
    int W, N, total, stepn, start_k, next_start, done_k;
    int we_cnt, start_cnt, last_we_k, last_start_k, resp_cnt, j, idx;
    int last_pt, last_wd, last_data;
    bit degen, waiting, fin, done_app, exp_we, exp_start;
    feat = 4'(f); data_points = 12'(d); epoch = 8'(e); learn_rate = 4'(l);
    RST = 1'b1; step_done = 1'b0;
    repeat (rc) begin
      @(posedge CLK); @(negedge CLK);
      chk_zero("rst");
    end
    degen = (d == 0) || (e == 0);
    W = degen ? 0 : d * (f + 1);
    N = 16 * W;
    total = degen ? 0 : d * e;
    while (words.size() < W) words.push_back(16'($urandom));
    stepn = 0; start_k = 0; next_start = N + 1; done_k = 0;
    waiting = 1'b0; fin = degen;
    we_cnt = 0; start_cnt = 0; last_we_k = 0; last_start_k = 0; resp_cnt = 0;
    last_pt = 0; last_wd = 0; last_data = 0;
    RST = 1'b0;
    S = (W > 0) ? words[0][0] : 1'b0;
    for (int k = 1; k <= N + total * 12 + 40; k++) begin
      done_app = step_done;
      @(posedge CLK); @(negedge CLK);
      if (!degen && waiting && done_app && k >= start_k + 2) begin
        stepn++;
        waiting = 1'b0;
        if (stepn == total) begin fin = 1'b1; done_k = k; end
        else next_start = k;
      end
      exp_start = !degen && !waiting && !fin && (k == next_start);
      if (exp_start) begin waiting = 1'b1; start_k = k; end
      exp_we = (k % 16 == 0) && (k / 16 >= 1) && (k / 16 <= W);
      if (exp_we) begin
        j = k / 16 - 1;
        last_pt = j / (f + 1);
        last_wd = f - (j % (f + 1));
        last_data = int'(words[j]);
      end
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      chk("mem_point", 32'(mem_point), 32'(last_pt));
      chk("mem_word", 32'(mem_word), 32'(last_wd));
      chk("mem_wdata", 32'(mem_wdata), 32'(last_data));
      chk("step_start", 32'(step_start), 32'(exp_start));
      chk("step_point", 32'(step_point), degen ? 0 : 32'(stepn % d));
      chk("step_epoch", 32'(step_epoch), degen ? 0 : 32'(stepn / d));
      chk("lr_out", 32'(lr_out), 32'(l));
      chk("busy", 32'(busy), 32'(!fin));
      chk("sgd_done", 32'(SGD_DONE), 32'(fin));
      if (mem_we) begin we_cnt++; last_we_k = k; end
      if (step_start) begin start_cnt++; last_start_k = k; end
      if (tag == 1 && k == 16) begin
        chk("ser_we0", 32'(mem_we), 1);
        chk("ser_word0", 32'(mem_word), 1);
        chk("ser_data0", 32'(mem_wdata), 32'h0000A5C3);
      end
      if (tag == 1 && k == 32) begin
        chk("ser_word1", 32'(mem_word), 0);
        chk("ser_data1", 32'(mem_wdata), 32'h00001234);
        chk("ser_nostart", 32'(step_start), 0);
      end
      if (tag == 1 && k == 33) chk("ser_start", 32'(step_start), 1);
      if (tag == 2 && k == 1) begin
        chk("rel_busy", 32'(busy), 1);
        chk("rel_lr", 32'(lr_out), 15);
      end
      if (tag == 3 && k == 112) begin
        chk("sch_start6", 32'(step_start), 1);
        chk("sch_pt6", 32'(step_point), 2);
        chk("sch_ep6", 32'(step_epoch), 1);
      end
      if (tag == 3 && k == 114) chk("sch_notdone", 32'(SGD_DONE), 0);
      if (tag == 3 && k == 115) chk("sch_done", 32'(SGD_DONE), 1);
      if (tag == 4 && k == 1) chk("deg_done", 32'(SGD_DONE), 1);
      if (abort && !degen && waiting && (stepn / d == 1)) begin
        RST = 1'b1; step_done = 1'b0;
        @(posedge CLK); @(negedge CLK);
        chk_zero("abort");
        words.delete();
        return;
      end
      if (fin && k >= done_k + 6) break;
      idx = k / 16;
      if (idx < W) S = words[idx][k % 16];
      else S = 1'($urandom);
      step_done = 1'b0;
      if (mode == 0) begin
        if (step_start) begin
          resp_cnt = 2;
          step_done = 1'b1;
        end else if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) step_done = 1'b1;
        end
        if (k == 3 || fin) step_done = 1'b1;
      end else begin
        step_done = ($urandom_range(3) == 0);
      end
    end
    step_done = 1'b0;
    chk("end_done", 32'(SGD_DONE), 1);
    if (tag == 1) chk("ser_wecnt", 32'(we_cnt), 2);
    if (tag == 2) begin
      chk("full_wecnt", 32'(we_cnt), 48);
      chk("full_lastwe", 32'(last_we_k), 768);
    end
    if (tag == 3) begin
      chk("sch_starts", 32'(start_cnt), 6);
      chk("sch_last", 32'(last_start_k), 112);
    end
    if (tag == 4) chk("deg_wecnt", 32'(we_cnt), 0);
    words.delete();
  endtask

  initial begin
    run_test(2, 11, 4, 100, 15, 1, 1'b0, 10);
    words.push_back(16'hA5C3);
    words.push_back(16'h1234);
    run_test(1, 1, 1, 1, 3, 0, 1'b0, 3);
    run_test(3, 1, 3, 2, 7, 0, 1'b0, 3);
    run_test(4, 3, 0, 5, 2, 1, 1'b0, 3);
    run_test(4, 2, 3, 0, 4, 0, 1'b0, 3);
    run_test(5, 2, 3, 3, 9, 1, 1'b1, 3);
    run_test(6, 2, 3, 3, 9, 0, 1'b0, 2);
    for (int r = 0; r < 6; r++) begin
      run_test(7, $urandom_range(5), 1 + $urandom_range(4), 1 + $urandom_range(3),
               $urandom_range(15), $urandom_range(1), 1'b0, 1 + $urandom_range(3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
